// File: rtl/simplerisc_pkg.sv
// Shared types and default widths for the SimpleRISC data-memory path.
package simplerisc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;

  // One queued response: load data (zero for stores/errors) plus range error flag.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } dmem_rsp_t;

  // Build a response entry; keeps the rdata=0-on-error rule in one place.
  function automatic dmem_rsp_t rsp_make(input logic [DATA_W-1:0] rdata, input logic err);
    dmem_rsp_t r;
    r.rdata = err ? '0 : rdata;
    r.err   = err;
    return r;
  endfunction

endpackage

// File: rtl/simplerisc_rsp_fifo.sv
// Small synchronous FIFO of dmem responses. Pointers wrap modulo DEPTH, so DEPTH
// need not be a power of two. Illegal pushes (full, no pop) and pops (empty) are dropped.
module simplerisc_rsp_fifo
  import simplerisc_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  dmem_rsp_t       din,
  output dmem_rsp_t       dout,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  dmem_rsp_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthC);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards any queued responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/simplerisc_dmem_responder.sv
// Responder side of the SimpleRISC load/store interface. Holds the word-addressed
// data memory and returns exactly one response per accepted request, in order.
// DATA_W must match simplerisc_pkg::DATA_W, since responses use the package struct.
module simplerisc_dmem_responder #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  import simplerisc_pkg::*;

  localparam int unsigned      IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CntW   = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_W:0]  DepthA = (ADDR_W + 1)'(DEPTH);
  localparam logic [CntW-1:0]  RspC   = CntW'(RSP_DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IdxW-1:0]   mem_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic              in_range;
  logic              push, pop;
  dmem_rsp_t         fifo_din, fifo_dout;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;

  // Address decode; the extra top bit keeps the compare correct when DEPTH == 2**ADDR_W.
  always_comb begin
    in_range  = ({1'b0, req_addr} < DepthA);
    mem_idx   = req_addr[IdxW-1:0];
    mem_rdata = mem[mem_idx];
  end

  // Handshakes and the response entry formed from this cycle's request.
  always_comb begin
    pop       = rsp_valid && rsp_ready;
    req_ready = !fifo_full || pop;
    push      = req_valid && req_ready;
    fifo_din  = rsp_make((req_we || !in_range) ? '0 : mem_rdata, !in_range);
  end

  // Memory write on store acceptance; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && req_we && in_range) mem[mem_idx] <= req_wdata;
  end

  simplerisc_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Response outputs read as zero whenever nothing is queued.
  always_comb begin
    rsp_valid = !fifo_empty;
    rsp_rdata = fifo_empty ? '0 : fifo_dout.rdata;
    rsp_err   = !fifo_empty && fifo_dout.err;
  end

  // Occupancy can never exceed the configured FIFO depth.
  a_count_bound: assert property (@(posedge clk) disable iff (!reset) fifo_count <= RspC);

endmodule
